// File: rtl/saturating_counter_predictor.sv
// rtl/saturating_counter_predictor.sv - gshare/bimodal table of saturating counters
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   lookup_valid        lookup request this cycle
//   lookup_address      branch address to predict
//   prediction_valid    registered: prediction/prediction_index valid
//   prediction          registered: 1 = taken (MSB of selected counter)
//   prediction_index    registered: table index used, returned later on update_index
//   update_valid        branch resolved this cycle
//   update_index        index previously reported on prediction_index
//   update_taken        resolved outcome
//   global_history      history register, bit 0 newest; 0 in bimodal mode
module saturating_counter_predictor #(
  parameter int ADDR_WIDTH = 4,
  parameter int CTR_WIDTH  = 2,
  parameter int HIST_WIDTH = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        lookup_valid,
  input  logic [ADDR_WIDTH-1:0]                       lookup_address,
  output logic                                        prediction_valid,
  output logic                                        prediction,
  output logic [ADDR_WIDTH-1:0]                       prediction_index,
  input  logic                                        update_valid,
  input  logic [ADDR_WIDTH-1:0]                       update_index,
  input  logic                                        update_taken,
  output logic [(HIST_WIDTH > 0 ? HIST_WIDTH : 1)-1:0] global_history
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  // Weakly-not-taken: just below the taken threshold (0 for 1-bit counters).
  localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;
  localparam logic [CTR_WIDTH-1:0] CTR_MIN  = '0;

  logic [CTR_WIDTH-1:0]  ctr_table [DEPTH];
  logic [ADDR_WIDTH-1:0] lookup_idx;
  logic [CTR_WIDTH-1:0]  update_cur;
  logic [CTR_WIDTH-1:0]  update_next;
  logic                  lookup_msb;

  // Index formation and history register. History only moves on resolution,
  // so lookups always hash with the committed (pre-edge) history.
  generate
    if (HIST_WIDTH == 0) begin : g_bimodal
      assign lookup_idx     = lookup_address;
      assign global_history = '0;
    end else begin : g_gshare
      logic [HIST_WIDTH-1:0] hist_q;

      if (HIST_WIDTH == 1) begin : g_hist1
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            hist_q <= '0;
          end else if (update_valid) begin
            hist_q <= update_taken;
          end
        end
      end else begin : g_histn
        always_ff @(posedge clk or posedge rst) begin
          if (rst) begin
            hist_q <= '0;
          end else if (update_valid) begin
            hist_q <= {hist_q[HIST_WIDTH-2:0], update_taken};
          end
        end
      end

      assign lookup_idx     = lookup_address ^ ADDR_WIDTH'(hist_q);
      assign global_history = hist_q;
    end
  endgenerate

  // Saturating increment/decrement of the counter being trained.
  always_comb begin
    update_cur  = ctr_table[update_index];
    update_next = update_cur;
    if (update_taken) begin
      if (update_cur != CTR_MAX) update_next = update_cur + 1'b1;
    end else begin
      if (update_cur != CTR_MIN) update_next = update_cur - 1'b1;
    end
  end

  // Same-cycle update to the looked-up entry: forward the trained value so
  // the prediction reflects the outcome that resolves on this edge.
  always_comb begin
    if (update_valid && (update_index == lookup_idx)) begin
      lookup_msb = update_next[CTR_WIDTH-1];
    end else begin
      lookup_msb = ctr_table[lookup_idx][CTR_WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr_table[i] <= CTR_INIT;
      end
    end else if (update_valid) begin
      ctr_table[update_index] <= update_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prediction_valid <= 1'b0;
      prediction       <= 1'b0;
      prediction_index <= '0;
    end else if (lookup_valid) begin
      prediction_valid <= 1'b1;
      prediction       <= lookup_msb;
      prediction_index <= lookup_idx;
    end else begin
      prediction_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_saturating_counter_predictor.sv
// tb/tb_saturating_counter_predictor.sv - directed bench for saturating_counter_predictor
module tb_saturating_counter_predictor;

  logic clk;
  logic rst;

  // gshare instance, default parameters
  logic       gs_lookup_valid;
  logic [3:0] gs_lookup_address;
  logic       gs_prediction_valid;
  logic       gs_prediction;
  logic [3:0] gs_prediction_index;
  logic       gs_update_valid;
  logic [3:0] gs_update_index;
  logic       gs_update_taken;
  logic [3:0] gs_global_history;

  // bimodal instance
  logic       bi_lookup_valid;
  logic [3:0] bi_lookup_address;
  logic       bi_prediction_valid;
  logic       bi_prediction;
  logic [3:0] bi_prediction_index;
  logic       bi_update_valid;
  logic [3:0] bi_update_index;
  logic       bi_update_taken;
  logic [0:0] bi_global_history;

  // bimodal instance with 3-bit counters
  logic       c3_lookup_valid;
  logic [3:0] c3_lookup_address;
  logic       c3_prediction_valid;
  logic       c3_prediction;
  logic [3:0] c3_prediction_index;
  logic       c3_update_valid;
  logic [3:0] c3_update_index;
  logic       c3_update_taken;
  logic [0:0] c3_global_history;

  int n_compared;
  int n_mismatched;

  saturating_counter_predictor #(.ADDR_WIDTH(4), .CTR_WIDTH(2), .HIST_WIDTH(4)) u_gs (
    .clk(clk), .rst(rst),
    .lookup_valid(gs_lookup_valid), .lookup_address(gs_lookup_address),
    .prediction_valid(gs_prediction_valid), .prediction(gs_prediction),
    .prediction_index(gs_prediction_index),
    .update_valid(gs_update_valid), .update_index(gs_update_index),
    .update_taken(gs_update_taken), .global_history(gs_global_history)
  );

  saturating_counter_predictor #(.ADDR_WIDTH(4), .CTR_WIDTH(2), .HIST_WIDTH(0)) u_bi (
    .clk(clk), .rst(rst),
    .lookup_valid(bi_lookup_valid), .lookup_address(bi_lookup_address),
    .prediction_valid(bi_prediction_valid), .prediction(bi_prediction),
    .prediction_index(bi_prediction_index),
    .update_valid(bi_update_valid), .update_index(bi_update_index),
    .update_taken(bi_update_taken), .global_history(bi_global_history)
  );

  saturating_counter_predictor #(.ADDR_WIDTH(4), .CTR_WIDTH(3), .HIST_WIDTH(0)) u_c3 (
    .clk(clk), .rst(rst),
    .lookup_valid(c3_lookup_valid), .lookup_address(c3_lookup_address),
    .prediction_valid(c3_prediction_valid), .prediction(c3_prediction),
    .prediction_index(c3_prediction_index),
    .update_valid(c3_update_valid), .update_index(c3_update_index),
    .update_taken(c3_update_taken), .global_history(c3_global_history)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gs_upd(input logic [3:0] idx, input logic taken);
    gs_update_valid = 1'b1;
    gs_update_index = idx;
    gs_update_taken = taken;
    step();
    gs_update_valid = 1'b0;
  endtask

  task automatic gs_look(input logic [3:0] addr);
    gs_lookup_valid   = 1'b1;
    gs_lookup_address = addr;
    step();
    gs_lookup_valid   = 1'b0;
  endtask

  task automatic bi_upd(input logic [3:0] idx, input logic taken);
    bi_update_valid = 1'b1;
    bi_update_index = idx;
    bi_update_taken = taken;
    step();
    bi_update_valid = 1'b0;
  endtask

  task automatic bi_look(input logic [3:0] addr);
    bi_lookup_valid   = 1'b1;
    bi_lookup_address = addr;
    step();
    bi_lookup_valid   = 1'b0;
  endtask

  task automatic c3_upd(input logic [3:0] idx, input logic taken);
    c3_update_valid = 1'b1;
    c3_update_index = idx;
    c3_update_taken = taken;
    step();
    c3_update_valid = 1'b0;
  endtask

  task automatic c3_look(input logic [3:0] addr);
    c3_lookup_valid   = 1'b1;
    c3_lookup_address = addr;
    step();
    c3_lookup_valid   = 1'b0;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    rst = 1'b1;
    gs_lookup_valid = 1'b0; gs_lookup_address = '0;
    gs_update_valid = 1'b0; gs_update_index = '0; gs_update_taken = 1'b0;
    bi_lookup_valid = 1'b0; bi_lookup_address = '0;
    bi_update_valid = 1'b0; bi_update_index = '0; bi_update_taken = 1'b0;
    c3_lookup_valid = 1'b0; c3_lookup_address = '0;
    c3_update_valid = 1'b0; c3_update_index = '0; c3_update_taken = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    check("rst_pvalid", gs_prediction_valid, 0);
    check("rst_pred",   gs_prediction, 0);
    check("rst_pidx",   gs_prediction_index, 0);
    check("rst_hist",   gs_global_history, 0);

    // First lookup after reset: weakly-not-taken, index = address
    gs_look(4'h3);
    check("lk3_pvalid", gs_prediction_valid, 1);
    check("lk3_pred",   gs_prediction, 0);
    check("lk3_pidx",   gs_prediction_index, 4'h3);
    check("lk3_hist",   gs_global_history, 0);
    step();
    check("idle_pvalid", gs_prediction_valid, 0);
    check("idle_pidx_hold", gs_prediction_index, 4'h3);

    // Forwarding: counter[2]=1, lookup 2 and taken update of 2 in one cycle
    check("fwd_hist_pre", gs_global_history, 0);
    gs_lookup_valid   = 1'b1;
    gs_lookup_address = 4'h2;
    gs_upd(4'h2, 1'b1);
    gs_lookup_valid   = 1'b0;
    check("fwd_pred", gs_prediction, 1);
    check("fwd_pidx", gs_prediction_index, 4'h2);
    check("fwd_hist_post", gs_global_history, 4'h1);

    // History: T,T,N,T from 0001 -> 0011,0111,1110,1101
    // counters: [4]=2 [5]=2 [6]=0 [7]=2, [2]=2 from forwarding test
    gs_upd(4'h4, 1'b1);
    gs_upd(4'h5, 1'b1);
    gs_upd(4'h6, 1'b0);
    gs_upd(4'h7, 1'b1);
    check("hist_1101", gs_global_history, 4'hD);
    gs_look(4'h6);                       // 6 ^ D = B, counter 1
    check("hash_pidx_b", gs_prediction_index, 4'hB);
    check("hash_pred_b", gs_prediction, 0);
    gs_look(4'hF);                       // F ^ D = 2, counter 2
    check("hash_pidx_2", gs_prediction_index, 4'h2);
    check("hash_pred_2", gs_prediction, 1);

    // Simultaneous lookup/update on different entries: independent
    gs_lookup_valid   = 1'b1;
    gs_lookup_address = 4'h8;            // 8 ^ D = 5, counter 2
    gs_upd(4'h6, 1'b0);                  // counter 6 stays 0
    gs_lookup_valid   = 1'b0;
    check("indep_pidx", gs_prediction_index, 4'h5);
    check("indep_pred", gs_prediction, 1);
    check("indep_hist", gs_global_history, 4'hA);
    gs_look(4'hC);                       // C ^ A = 6, counter 0
    check("indep_ctr6", gs_prediction, 0);

    // Bimodal saturation on index 5
    for (int i = 0; i < 4; i++) bi_upd(4'h5, 1'b1);
    bi_look(4'h5);
    check("bi_sat_hi_pred", bi_prediction, 1);
    check("bi_pidx", bi_prediction_index, 4'h5);
    check("bi_hist", bi_global_history, 0);
    bi_upd(4'h5, 1'b0);                  // 3 -> 2
    bi_look(4'h5);
    check("bi_dec1_pred", bi_prediction, 1);
    for (int i = 0; i < 3; i++) bi_upd(4'h5, 1'b0);  // 2 -> 1 -> 0 -> 0
    bi_look(4'h5);
    check("bi_sat_lo_pred", bi_prediction, 0);
    bi_upd(4'h5, 1'b1);                  // 0 -> 1, still not taken
    bi_look(4'h5);
    check("bi_lo_plus1", bi_prediction, 0);

    // 3-bit counters: reset value 3, threshold 4, saturate at 7
    c3_look(4'h0);
    check("c3_rst_pred", c3_prediction, 0);
    c3_upd(4'h0, 1'b1);                  // 3 -> 4
    c3_look(4'h0);
    check("c3_inc_pred", c3_prediction, 1);
    for (int i = 0; i < 7; i++) c3_upd(4'h0, 1'b1);  // saturates at 7
    c3_look(4'h0);
    check("c3_sat_pred", c3_prediction, 1);
    for (int i = 0; i < 3; i++) c3_upd(4'h0, 1'b0);  // 7 -> 4
    c3_look(4'h0);
    check("c3_dec3_pred", c3_prediction, 1);
    c3_upd(4'h0, 1'b0);                  // 4 -> 3
    c3_look(4'h0);
    check("c3_dec4_pred", c3_prediction, 0);

    // Async reset mid-stream during back-to-back lookups of trained entry 4
    // history is A, so address E hashes to index 4 (counter 2)
    gs_lookup_valid   = 1'b1;
    gs_lookup_address = 4'hE;
    step();
    step();
    check("pre_rst_pidx", gs_prediction_index, 4'h4);
    check("pre_rst_pred", gs_prediction, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_pvalid", gs_prediction_valid, 0);
    check("async_pred",   gs_prediction, 0);
    check("async_hist",   gs_global_history, 0);
    step();
    #2;
    rst = 1'b0;
    gs_lookup_address = 4'h4;
    step();
    gs_lookup_valid = 1'b0;
    check("post_rst_pvalid", gs_prediction_valid, 1);
    check("post_rst_pidx",   gs_prediction_index, 4'h4);
    check("post_rst_pred",   gs_prediction, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
